// File: rtl/textbuf_ctrl_pkg.sv
// Shared constants, parser state encoding and byte classifiers for the
// text buffer controller and its storage array.
package textbuf_ctrl_pkg;

    localparam int ADDR_W = 3;

    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_ESC   = 8'h1B;
    localparam logic [7:0] CHR_RND   = 8'h72;
    localparam logic [7:0] BLANK_CHR = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ESC   = 2'd1,
        S_CLEAR = 2'd2
    } parse_state_t;

    // Printable ASCII range that lands in the buffer as a character.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    // ESC argument '0'..'?' selects a fixed colour from the low nibble.
    function automatic logic is_color_cmd(input logic [7:0] b);
        return b[7:4] == 4'h3;
    endfunction

endpackage

// File: rtl/textbuf_mem.sv
// Character/colour register array: one write port, one registered read
// port, every entry reset to the blank character with colour 0.
module textbuf_mem
    import textbuf_ctrl_pkg::*;
#(
    parameter int         DEPTH   = 8,
    parameter int         COLOR_W = 4,
    parameter logic [7:0] BLANK   = BLANK_CHR
) (
    input  logic               clk20,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [7:0]         wr_char,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_ack,
    output logic [7:0]         rd_char,
    output logic [COLOR_W-1:0] rd_color
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [7:0]         char_mem  [DEPTH];
    logic [COLOR_W-1:0] color_mem [DEPTH];

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;

    // Storage array: blank on reset, single write port otherwise.
    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                char_mem[i]  <= BLANK;
                color_mem[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            char_mem[wr_addr]  <= wr_char;
            color_mem[wr_addr] <= wr_color;
        end
    end

    // Registered read port; out-of-range addresses read as a blank cell.
    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            rd_ack   <= 1'b0;
            rd_char  <= BLANK;
            rd_color <= '0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                if (rd_in_range) begin
                    rd_char  <= char_mem[rd_addr];
                    rd_color <= color_mem[rd_addr];
                end else begin
                    rd_char  <= BLANK;
                    rd_color <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/textbuf_ctrl.sv
// Text buffer controller: parses the UART byte stream into buffer
// operations and slots the resulting writes around refresh reads and
// the refresh frame lock, so a frame never shows half-updated text.
module textbuf_ctrl
    import textbuf_ctrl_pkg::*;
#(
    parameter int         MAX_CHARS = 8,
    parameter int         NUM_CHARS = 4,
    parameter int         COLOR_W   = 4,
    parameter logic [7:0] BLANK     = BLANK_CHR
) (
    input  logic               clk20,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic [COLOR_W-1:0] rnd_color,
    input  logic               frame_lock,
    input  logic               rd_req,
    input  logic [2:0]         rd_addr,
    output logic               rd_ack,
    output logic [7:0]         rd_char,
    output logic [COLOR_W-1:0] rd_color,
    output logic [2:0]         cursor,
    output logic               busy
);

    localparam logic [ADDR_W-1:0] CUR_LAST = ADDR_W'(NUM_CHARS - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MAX_CHARS - 1);

    parse_state_t        state_q, state_d;
    logic                pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [7:0]          pend_char_q, pend_char_d;
    logic [COLOR_W-1:0]  pend_color_q, pend_color_d;
    logic [ADDR_W-1:0]   cursor_q, cursor_d;
    logic                fixed_mode_q, fixed_mode_d;
    logic [COLOR_W-1:0]  fixed_color_q, fixed_color_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic                run_q;

    logic                accept;
    logic                commit_ok;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          wr_char;
    logic [COLOR_W-1:0]  wr_color;

    // run_q keeps rx_ready low while reset is held and for the release cycle.
    assign rx_ready  = run_q && !pend_valid_q && !frame_lock &&
                       ((state_q == S_IDLE) || (state_q == S_ESC));
    assign accept    = rx_valid && rx_ready;
    assign commit_ok = !rd_req && !frame_lock;
    assign busy      = pend_valid_q || (state_q == S_CLEAR);
    assign cursor    = cursor_q;

    // Parser, cursor and write-slot registers.
    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            pend_char_q   <= BLANK;
            pend_color_q  <= '0;
            cursor_q      <= '0;
            fixed_mode_q  <= 1'b0;
            fixed_color_q <= '0;
            clr_idx_q     <= '0;
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            pend_char_q   <= pend_char_d;
            pend_color_q  <= pend_color_d;
            cursor_q      <= cursor_d;
            fixed_mode_q  <= fixed_mode_d;
            fixed_color_q <= fixed_color_d;
            clr_idx_q     <= clr_idx_d;
            run_q         <= 1'b1;
        end
    end

    // Byte decode, clear sequencing and commit of the pending write.
    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        pend_char_d   = pend_char_q;
        pend_color_d  = pend_color_q;
        cursor_d      = cursor_q;
        fixed_mode_d  = fixed_mode_q;
        fixed_color_d = fixed_color_q;
        clr_idx_d     = clr_idx_q;
        wr_en         = 1'b0;
        wr_addr       = pend_addr_q;
        wr_char       = pend_char_q;
        wr_color      = pend_color_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_printable(rx_data)) begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = cursor_q;
                        pend_char_d  = rx_data;
                        pend_color_d = fixed_mode_q ? fixed_color_q : rnd_color;
                    end else if (rx_data == CHR_CR) begin
                        cursor_d = '0;
                    end else if (rx_data == CHR_FF) begin
                        state_d   = S_CLEAR;
                        clr_idx_d = '0;
                    end else if (rx_data == CHR_ESC) begin
                        state_d = S_ESC;
                    end
                end
            end
            S_ESC: begin
                if (accept) begin
                    if (is_color_cmd(rx_data)) begin
                        fixed_mode_d  = 1'b1;
                        fixed_color_d = COLOR_W'(rx_data[3:0]);
                    end else if (rx_data == CHR_RND) begin
                        fixed_mode_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (commit_ok) begin
                    wr_en    = 1'b1;
                    wr_addr  = clr_idx_q;
                    wr_char  = BLANK;
                    wr_color = '0;
                    if (clr_idx_q == CLR_LAST) begin
                        clr_idx_d = '0;
                        cursor_d  = '0;
                        state_d   = S_IDLE;
                    end else begin
                        clr_idx_d = clr_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A pending write can only exist in S_IDLE with no byte being accepted.
        if (pend_valid_q && commit_ok) begin
            wr_en        = 1'b1;
            wr_addr      = pend_addr_q;
            wr_char      = pend_char_q;
            wr_color     = pend_color_q;
            pend_valid_d = 1'b0;
            cursor_d     = (cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1;
        end
    end

    textbuf_mem #(
        .DEPTH   (MAX_CHARS),
        .COLOR_W (COLOR_W),
        .BLANK   (BLANK)
    ) u_mem (
        .clk20    (clk20),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_char  (wr_char),
        .wr_color (wr_color),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_char  (rd_char),
        .rd_color (rd_color)
    );

endmodule

// File: tb/tb_textbuf_ctrl.sv
// Self-checking bench for textbuf_ctrl: a byte-level model of the buffer
// predicts read data, expected reads are queued when issued and checked
// when rd_ack returns.
module tb_textbuf_ctrl;

    logic       clk20;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] rnd_color;
    logic       frame_lock;
    logic       rd_req;
    logic [2:0] rd_addr;
    logic       rd_ack;
    logic [7:0] rd_char;
    logic [3:0] rd_color;
    logic [2:0] cursor;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [11:0] exp_q[$];

    logic [7:0] model_char  [8];
    logic [3:0] model_color [8];
    logic [2:0] model_cursor;
    logic       model_fixed;
    logic [3:0] model_fixed_color;
    logic       model_esc;

    textbuf_ctrl dut (
        .clk20      (clk20),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rnd_color  (rnd_color),
        .frame_lock (frame_lock),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_char    (rd_char),
        .rd_color   (rd_color),
        .cursor     (cursor),
        .busy       (busy)
    );

    // 20 MHz clock.
    initial clk20 = 1'b0;
    always #25 clk20 = ~clk20;

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            model_char[i]  = 8'h20;
            model_color[i] = 4'h0;
        end
        model_cursor      = 3'd0;
        model_fixed       = 1'b0;
        model_fixed_color = 4'h0;
        model_esc         = 1'b0;
    endfunction

    // Applies one accepted byte to the model, as seen once it has committed.
    function automatic void model_byte(input logic [7:0] b);
        if (model_esc) begin
            if (b >= 8'h30 && b <= 8'h3F) begin
                model_fixed       = 1'b1;
                model_fixed_color = b[3:0];
            end else if (b == 8'h72) begin
                model_fixed = 1'b0;
            end
            model_esc = 1'b0;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            model_char[model_cursor]  = b;
            model_color[model_cursor] = model_fixed ? model_fixed_color : rnd_color;
            model_cursor = (model_cursor == 3'd3) ? 3'd0 : model_cursor + 3'd1;
        end else if (b == 8'h0D) begin
            model_cursor = 3'd0;
        end else if (b == 8'h0C) begin
            for (int i = 0; i < 8; i++) begin
                model_char[i]  = 8'h20;
                model_color[i] = 4'h0;
            end
            model_cursor = 3'd0;
        end else if (b == 8'h1B) begin
            model_esc = 1'b1;
        end
    endfunction

    // Scoreboard consumer: every rd_ack must match the oldest issued read.
    always @(negedge clk20) begin
        logic [11:0] exp;
        if (rd_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("rd_spurious_ack", 32'(rd_ack), 32'd0);
            end else begin
                exp = exp_q.pop_front();
                checkOutput("rd_char", 32'(rd_char), 32'(exp[11:4]));
                checkOutput("rd_color", 32'(rd_color), 32'(exp[3:0]));
            end
        end
    end

    // Offers one byte and waits (bounded) for it to be accepted.
    task automatic applyStimulus(input logic [7:0] b);
        logic acc;
        int   cnt;
        acc = 1'b0;
        cnt = 0;
        @(posedge clk20);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc && cnt < 100) begin
            @(negedge clk20);
            if (rx_ready === 1'b1) acc = 1'b1;
            @(posedge clk20);
            cnt++;
        end
        #1;
        rx_valid = 1'b0;
        checkOutput("rx_accept", 32'(acc), 32'd1);
    endtask

    task automatic waitIdle();
        int cnt;
        cnt = 0;
        @(negedge clk20);
        while (busy !== 1'b0 && cnt < 100) begin
            @(negedge clk20);
            cnt++;
        end
        checkOutput("wait_idle", 32'(busy), 32'd0);
    endtask

    // Held rd_req over consecutive addresses, one read per cycle.
    task automatic readRange(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk20);
            #1;
            rd_req  = 1'b1;
            rd_addr = 3'(i);
            exp_q.push_back({model_char[i], model_color[i]});
        end
        @(posedge clk20);
        #1;
        rd_req = 1'b0;
        @(negedge clk20);
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i]);
            model_byte(s[i]);
            waitIdle();
        end
    endtask

    task automatic releaseReset();
        @(posedge clk20);
        #1;
        reset = 1'b0;
        @(posedge clk20);
        @(negedge clk20);
        checkOutput("rx_ready_after_reset", 32'(rx_ready), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        checkOutput({tag, "_rd_ack"}, 32'(rd_ack), 32'd0);
        checkOutput({tag, "_rd_char"}, 32'(rd_char), 32'h20);
        checkOutput({tag, "_rd_color"}, 32'(rd_color), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_cursor"}, 32'(cursor), 32'd0);
    endtask

    initial begin
        logic [2:0] target;

        reset      = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        rnd_color  = 4'h0;
        frame_lock = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = 3'd0;
        model_reset();

        // Reset state and blank buffer.
        #60;
        checkResetOutputs("reset");
        releaseReset();
        readRange(0, 7);

        // Random-colour writes with cursor wrap.
        rnd_color = 4'h5;
        sendString("ABCDE");
        checkOutput("cursor_wrap", 32'(cursor), 32'(model_cursor));
        checkOutput("cursor_wrap_abs", 32'(cursor), 32'd1);
        readRange(0, 7);

        // Fixed colour, ignored escape argument, back to random colour.
        rnd_color = 4'h2;
        sendString({8'h1B, "7X", 8'h1B, "zV", 8'h1B, "rY"});
        checkOutput("cursor_esc", 32'(cursor), 32'(model_cursor));
        readRange(0, 7);

        // Write commit stalled by a held read.
        target = model_cursor;
        @(posedge clk20);
        #1;
        rx_data  = "Q";
        rx_valid = 1'b1;
        rd_req   = 1'b1;
        rd_addr  = target;
        exp_q.push_back({model_char[target], model_color[target]});
        @(negedge clk20);
        checkOutput("stall_accept", 32'(rx_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk20);
            #1;
            rx_valid = 1'b0;
            if (i < 3) exp_q.push_back({model_char[target], model_color[target]});
            else rd_req = 1'b0;
            @(negedge clk20);
            checkOutput("stall_busy", 32'(busy), 32'd1);
            checkOutput("stall_rx_ready", 32'(rx_ready), 32'd0);
            checkOutput("stall_cursor", 32'(cursor), 32'(target));
        end
        model_byte("Q");
        @(negedge clk20);
        checkOutput("commit_busy", 32'(busy), 32'd0);
        checkOutput("commit_rx_ready", 32'(rx_ready), 32'd1);
        checkOutput("commit_cursor", 32'(cursor), 32'(model_cursor));
        readRange(32'(target), 32'(target));

        // Clear paused by frame_lock after three entries.
        applyStimulus(8'h0C);
        repeat (3) @(posedge clk20);
        #1;
        frame_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_char[i]  = 8'h20;
            model_color[i] = 4'h0;
        end
        @(negedge clk20);
        checkOutput("lock_busy", 32'(busy), 32'd1);
        checkOutput("lock_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("lock_cursor", 32'(cursor), 32'(model_cursor));
        readRange(0, 7);
        checkOutput("lock_busy_end", 32'(busy), 32'd1);
        @(posedge clk20);
        #1;
        frame_lock = 1'b0;
        model_byte(8'h0C);
        waitIdle();
        checkOutput("clear_cursor", 32'(cursor), 32'd0);
        readRange(0, 7);

        // Reset in the middle of a clear.
        sendString("MNOP");
        applyStimulus(8'h0C);
        @(posedge clk20);
        #1;
        reset = 1'b1;
        #1;
        checkResetOutputs("rst_clear");
        model_reset();
        releaseReset();
        readRange(0, 7);

        // Reset in the middle of an escape sequence.
        sendString({8'h1B, "5"});
        applyStimulus(8'h1B);
        #1;
        reset = 1'b1;
        #1;
        checkResetOutputs("rst_esc");
        model_reset();
        releaseReset();
        rnd_color = 4'h3;
        sendString("5");
        checkOutput("post_esc_cursor", 32'(cursor), 32'd1);
        readRange(0, 1);

        repeat (3) @(negedge clk20);
        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
